// File: rtl/score_vector_packer.sv
// Gathers one frame of signed class scores from the serial FC output into a packed
// vector for the argmax stage, checking frame boundaries against s_last.
module score_vector_packer #(
  parameter int BIT_WIDTH   = 8,
  parameter int NUM_CLASSES = 10,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [BIT_WIDTH-1:0]             s_data,
  input  logic                             s_last,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [BIT_WIDTH*NUM_CLASSES-1:0] m_vec,
  output logic                             frame_err,
  input  logic                             err_clr
);

  localparam int VEC_W = BIT_WIDTH * NUM_CLASSES;
  localparam logic [CNT_WIDTH-1:0] LAST_SLOT = CNT_WIDTH'(NUM_CLASSES - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t                 state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic signed [BIT_WIDTH-1:0] score_p0;
  logic                   accept;
  logic                   at_last_slot;
  logic                   early_last;
  logic                   missing_last;
  logic                   take;

  // Scores are stored bit-exact; the signed view only documents the payload type.
  function automatic logic [VEC_W-1:0] put_slot(
    input logic [VEC_W-1:0]            vec,
    input logic [CNT_WIDTH-1:0]        idx,
    input logic signed [BIT_WIDTH-1:0] score
  );
    logic [VEC_W-1:0] r;
    r = vec;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (idx == CNT_WIDTH'(i)) begin
        r[i*BIT_WIDTH +: BIT_WIDTH] = score;
      end
    end
    return r;
  endfunction

  assign score_p0     = s_data;
  assign accept       = s_valid & s_ready;
  assign at_last_slot = (cnt == LAST_SLOT);
  assign early_last   = accept & ~at_last_slot & s_last;
  assign missing_last = accept & at_last_slot & ~s_last;
  assign take         = m_valid & m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      cnt       <= '0;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      m_vec     <= '0;
      frame_err <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          // s_ready is low only on the first cycle out of reset while collecting.
          s_ready <= 1'b1;
          if (accept) begin
            m_vec <= put_slot(m_vec, cnt, score_p0);
            if (at_last_slot) begin
              cnt     <= '0;
              state   <= PRESENT;
              m_valid <= 1'b1;
              s_ready <= 1'b0;
            end else if (s_last) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
        end
        PRESENT: begin
          if (take) begin
            m_valid <= 1'b0;
            state   <= COLLECT;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= COLLECT;
          s_ready <= 1'b0;
          m_valid <= 1'b0;
        end
      endcase

      // A new framing error wins over a clear arriving in the same cycle.
      if (early_last | missing_last) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_score_vector_packer.sv
// Scoreboard bench for score_vector_packer: expected vectors are queued as frames are
// driven and compared whenever the packer presents a vector.
module tb_score_vector_packer;

  localparam int BW = 8;
  localparam int NC = 10;
  localparam int VW = BW * NC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [BW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [VW-1:0] m_vec;
  logic          frame_err;
  logic          err_clr = 1'b0;

  int total = 0;
  int bad = 0;
  logic [VW-1:0] exp_q[$];

  score_vector_packer #(.BIT_WIDTH(BW), .NUM_CLASSES(NC), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_vec(m_vec),
    .frame_err(frame_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] pack_vec(input logic [BW-1:0] v [NC]);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < NC; i++) r[i*BW +: BW] = v[i];
    return r;
  endfunction

  function automatic logic [VW-1:0] pop_exp();
    logic [VW-1:0] e;
    e = 'x;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    return e;
  endfunction

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic beat(input logic [BW-1:0] d, input logic l);
    int guard;
    guard = 0;
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    while (!s_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      total++; bad++;
      $display("FAIL beat_timeout s_ready=%0b want=1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic send_frame(input logic [BW-1:0] v [NC], input logic last_ok);
    exp_q.push_back(pack_vec(v));
    for (int i = 0; i < NC; i++) beat(v[i], (i == NC - 1) && last_ok);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready got=%b want=0", s_ready); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b want=0", m_valid); end
    total++; if (m_vec !== '0) begin bad++; $display("FAIL rst_m_vec got=%h want=0", m_vec); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_frame_err got=%b want=0", frame_err); end
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_release_s_ready got=%b want=0", s_ready); end
    @(negedge clk);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL post_rst_s_ready got=%b want=1", s_ready); end
  endtask

  task automatic test_single_frame();
    logic [BW-1:0] v [NC];
    logic [VW-1:0] e;
    v = '{8'hFD, 8'h05, 8'h80, 8'h00, 8'h11, 8'h7F, 8'hFF, 8'h02, 8'h09, 8'hF9};
    m_ready = 1'b1;
    send_frame(v, 1'b1);
    e = pop_exp();
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL single_m_valid got=%b want=1", m_valid); end
    total++; if (m_vec !== e) begin bad++; $display("FAIL single_m_vec got=%h want=%h", m_vec, e); end
    total++; if (m_vec[47:40] !== 8'h7F) begin bad++; $display("FAIL single_slot5 got=%h want=7f", m_vec[47:40]); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL single_frame_err got=%b want=0", frame_err); end
    @(negedge clk);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL single_one_cycle got=%b want=0", m_valid); end
  endtask

  task automatic test_stall();
    logic [BW-1:0] v [NC];
    logic [VW-1:0] e;
    v = '{8'hFD, 8'h05, 8'h80, 8'h00, 8'h11, 8'h7F, 8'hFF, 8'h02, 8'h09, 8'hF9};
    m_ready = 1'b0;
    send_frame(v, 1'b1);
    e = pop_exp();
    for (int c = 0; c < 6; c++) begin
      s_valid = 1'b1;
      s_data = BW'($urandom);
      @(negedge clk);
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL stall_s_ready c=%0d got=%b want=0", c, s_ready); end
      total++; if (m_vec !== e) begin bad++; $display("FAIL stall_m_vec c=%0d got=%h want=%h", c, m_vec, e); end
      total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL stall_m_valid c=%0d got=%b want=1", c, m_valid); end
    end
    // Handshake cycle with a live beat offered; it must not be taken.
    m_ready = 1'b1;
    s_data = 8'h55;
    @(negedge clk);
    s_valid = 1'b0;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL hs_m_valid got=%b want=0", m_valid); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL hs_s_ready got=%b want=1", s_ready); end
    for (int i = 0; i < NC; i++) v[i] = BW'(i * 3 + 1);
    send_frame(v, 1'b1);
    e = pop_exp();
    total++; if (m_vec !== e) begin bad++; $display("FAIL after_hs_m_vec got=%h want=%h", m_vec, e); end
    @(negedge clk);
  endtask

  task automatic test_early_last();
    logic [BW-1:0] v [NC];
    logic [VW-1:0] e;
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL early_pre_err got=%b want=0", frame_err); end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) beat(BW'(i + 1), i == 3);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL early_err got=%b want=1", frame_err); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL early_no_vec got=%b want=0", m_valid); end
    for (int i = 0; i < NC; i++) v[i] = BW'(10 + i);
    send_frame(v, 1'b1);
    e = pop_exp();
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL early_next_valid got=%b want=1", m_valid); end
    total++; if (m_vec !== e) begin bad++; $display("FAIL early_next_vec got=%h want=%h", m_vec, e); end
    @(negedge clk);
  endtask

  task automatic test_missing_last();
    logic [BW-1:0] v [NC];
    logic [VW-1:0] e;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL clr1_err got=%b want=0", frame_err); end
    m_ready = 1'b1;
    for (int i = 0; i < NC; i++) v[i] = BW'(8'hE0 + i);
    send_frame(v, 1'b0);
    e = pop_exp();
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL miss_valid got=%b want=1", m_valid); end
    total++; if (m_vec !== e) begin bad++; $display("FAIL miss_vec got=%h want=%h", m_vec, e); end
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL miss_err got=%b want=1", frame_err); end
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL clr2_err got=%b want=0", frame_err); end
    err_clr = 1'b1;
    beat(8'h01, 1'b1);
    err_clr = 1'b0;
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL set_beats_clr got=%b want=1", frame_err); end
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] v [NC];
    logic [VW-1:0] e;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) beat(BW'(8'h40 + i), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_s_ready got=%b want=0", s_ready); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_m_valid got=%b want=0", m_valid); end
    total++; if (m_vec !== '0) begin bad++; $display("FAIL mid_rst_m_vec got=%h want=0", m_vec); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL mid_rst_err got=%b want=0", frame_err); end
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < NC; i++) v[i] = BW'(i);
    send_frame(v, 1'b1);
    e = pop_exp();
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL mid_next_valid got=%b want=1", m_valid); end
    total++; if (m_vec !== e) begin bad++; $display("FAIL mid_next_vec got=%h want=%h", m_vec, e); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int got;
    int guard;
    got = 0;
    guard = 0;
    fork
      begin
        logic [BW-1:0] v [NC];
        for (int f = 0; f < 200; f++) begin
          for (int i = 0; i < NC; i++) v[i] = BW'($urandom);
          exp_q.push_back(pack_vec(v));
          for (int i = 0; i < NC; i++) begin
            s_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            beat(v[i], i == NC - 1);
          end
        end
      end
      begin
        logic [VW-1:0] e;
        while (got < 200 && guard < 20000) begin
          m_ready = 1'($urandom_range(0, 1));
          if (m_valid && m_ready) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++; $display("FAIL rand_extra_vec got=%h want=none", m_vec);
            end else begin
              e = exp_q.pop_front();
              if (m_vec !== e) begin bad++; $display("FAIL rand_vec n=%0d got=%h want=%h", got, m_vec, e); end
            end
            got++;
          end
          @(negedge clk);
          guard++;
        end
      end
    join
    m_ready = 1'b1;
    total++; if (got != 200) begin bad++; $display("FAIL rand_count got=%0d want=200", got); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_left got=%0d want=0", exp_q.size()); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rand_err got=%b want=0", frame_err); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_stall();
    test_early_last();
    test_missing_last();
    test_reset_mid();
    // Clear the sticky flag left by the earlier error scenarios? Reset above already did.
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
